// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if
// Bundles the fetch requester, debug/loader requester and ROM-side signals
// of the instruction-memory arbiter.
//   slave  : arbiter side (takes i_* signals, drives o_* signals)
//   master : environment side (drives i_* signals, observes o_* signals)
// Fetch   : i_if_valid, i_if_addr, o_if_ready, i_if_flush,
//           o_if_rvalid, o_if_rdata, o_if_err
// Debug   : i_dbg_valid, i_dbg_addr, o_dbg_ready,
//           o_dbg_rvalid, o_dbg_rdata, o_dbg_err
// ROM     : o_mem_en, o_mem_addr, i_mem_rdata
interface imem_arbiter_if;
  logic        i_if_valid;
  logic [31:0] i_if_addr;
  logic        o_if_ready;
  logic        i_if_flush;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        o_if_err;

  logic        i_dbg_valid;
  logic [31:0] i_dbg_addr;
  logic        o_dbg_ready;
  logic        o_dbg_rvalid;
  logic [31:0] o_dbg_rdata;
  logic        o_dbg_err;

  logic        o_mem_en;
  logic [31:0] o_mem_addr;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_if_valid, i_if_addr, i_if_flush,
    input  i_dbg_valid, i_dbg_addr,
    input  i_mem_rdata,
    output o_if_ready, o_if_rvalid, o_if_rdata, o_if_err,
    output o_dbg_ready, o_dbg_rvalid, o_dbg_rdata, o_dbg_err,
    output o_mem_en, o_mem_addr
  );

  modport master (
    output i_if_valid, i_if_addr, i_if_flush,
    output i_dbg_valid, i_dbg_addr,
    output i_mem_rdata,
    input  o_if_ready, o_if_rvalid, o_if_rdata, o_if_err,
    input  o_dbg_ready, o_dbg_rvalid, o_dbg_rdata, o_dbg_err,
    input  o_mem_en, o_mem_addr
  );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter
// Two-requester read arbiter in front of a single-port instruction ROM.
// Fetch has fixed priority; the debug/loader port is promoted once it has
// been denied STARVE_MAX consecutive cycles. One grant per cycle, response
// exactly one cycle later on the owning port. Illegal addresses (misaligned
// or beyond BYTES) are accepted but answered with an error and a NOP word
// without touching the ROM.
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset (also forces outputs to idle)
//   bus     : imem_arbiter_if.slave (fetch, debug and ROM signals)
module imem_arbiter #(
  parameter int BYTES      = 8192,
  parameter int STARVE_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  imem_arbiter_if.slave bus
);

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [31:0] ADDR_LIM   = 32'(BYTES);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  owner_e      owner_q, owner_d;
  logic        err_q, err_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic        dbg_force;
  logic        grant_if;
  logic        grant_dbg;
  logic        gnt_legal;
  logic [31:0] gnt_addr;
  logic        if_resp;
  logic        dbg_resp;

  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < ADDR_LIM);
  endfunction

  // Grant / next-state stage
  always_comb begin
    owner_d    = OWN_NONE;
    err_d      = 1'b0;
    starve_d   = starve_q;
    mem_addr_d = mem_addr_q;

    // Forced priority only matters while dbg is actually asking.
    dbg_force = bus.i_dbg_valid && (starve_q == STARVE_LIM);
    grant_if  = !i_reset && bus.i_if_valid && !dbg_force;
    grant_dbg = !i_reset && bus.i_dbg_valid && !grant_if;
    gnt_addr  = grant_dbg ? bus.i_dbg_addr : bus.i_if_addr;
    gnt_legal = (grant_if || grant_dbg) && addr_legal(gnt_addr);

    if (grant_if) begin
      owner_d = OWN_IF;
    end else if (grant_dbg) begin
      owner_d = OWN_DBG;
    end
    err_d = (grant_if || grant_dbg) && !gnt_legal;

    // Presented address holds its last value when the ROM is not read.
    if (gnt_legal) begin
      mem_addr_d = {gnt_addr[31:2], 2'b00};
    end

    if (!bus.i_dbg_valid || grant_dbg) begin
      starve_d = 4'd0;
    end else if (starve_q < STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end

    if (i_reset) begin
      owner_d    = OWN_NONE;
      err_d      = 1'b0;
      starve_d   = 4'd0;
      mem_addr_d = 32'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    owner_q    <= owner_d;
    err_q      <= err_d;
    starve_q   <= starve_d;
    mem_addr_q <= mem_addr_d;
  end

  assign bus.o_if_ready  = grant_if;
  assign bus.o_dbg_ready = grant_dbg;
  assign bus.o_mem_en    = gnt_legal;
  assign bus.o_mem_addr  = mem_addr_d;

  // Response stage: reset masks a response still owed from before reset,
  // flush masks only the fetch side.
  assign if_resp  = !i_reset && (owner_q == OWN_IF);
  assign dbg_resp = !i_reset && (owner_q == OWN_DBG);

  assign bus.o_if_rvalid  = if_resp && !bus.i_if_flush;
  assign bus.o_if_err     = bus.o_if_rvalid && err_q;
  assign bus.o_if_rdata   = bus.o_if_rvalid ? (err_q ? NOP : bus.i_mem_rdata) : 32'd0;

  assign bus.o_dbg_rvalid = dbg_resp;
  assign bus.o_dbg_err    = dbg_resp && err_q;
  assign bus.o_dbg_rdata  = dbg_resp ? (err_q ? NOP : bus.i_mem_rdata) : 32'd0;

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter BYTES, default 8192: instruction memory size in bytes; legal byte addresses are 0..BYTES-1.
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive denied dbg cycles before dbg gets forced priority, range 1..15.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port i_reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_if_valid  input  1  fetch request valid.
REQ-006 SHALL have port i_if_addr  input  32  fetch byte address.
REQ-007 SHALL have port o_if_ready  output  1  fetch request accepted this cycle (combinational grant).
REQ-008 SHALL have port i_if_flush  input  1  kill any in-flight fetch response (branch/redirect).
REQ-009 SHALL have port o_if_rvalid  output  1  fetch response valid.
REQ-010 SHALL have port o_if_rdata  output  32  fetch response data.
REQ-011 SHALL have port o_if_err  output  1  fetch response is an error (misaligned or out of range).
REQ-012 SHALL have ports i_dbg_valid (input 1), i_dbg_addr (input 32), o_dbg_ready (output 1), o_dbg_rvalid (output 1), o_dbg_rdata (output 32) and o_dbg_err (output 1), with the same meanings as the fetch ports for the debug/loader read requester.
REQ-013 SHALL have port o_mem_en  output  1  memory read strobe.
REQ-014 SHALL have port o_mem_addr  output  32  byte address to the ROM, with bits [1:0] forced to 0.
REQ-015 SHALL have port i_mem_rdata  input  32  ROM data, valid the cycle after o_mem_en.

Function
REQ-016 SHALL grant at most one request per cycle; a request is accepted when valid && ready are both high in the same cycle.
REQ-017 SHALL give fetch fixed priority over dbg when starve_cnt < STARVE_MAX.
REQ-018 SHALL give dbg priority when starve_cnt == STARVE_MAX, with fetch denied that cycle.
REQ-019 starve_cnt SHALL be a 4-bit counter: +1 on each cycle dbg is valid and not granted, saturating at STARVE_MAX; cleared to 0 on a dbg grant or when i_dbg_valid is low.
REQ-020 SHALL compute o_if_ready and o_dbg_ready combinationally from the valids and starve_cnt; ready SHALL be low when the same port's valid is low.
REQ-021 SHALL have 1-cycle response latency for a granted request: rvalid is asserted on the owning port in the next cycle only, and the other port's rvalid stays low.
REQ-022 SHALL sustain back-to-back grants, one per cycle, with no bubble; each response stays routed to its own requester.
REQ-023 For a legal address (addr[1:0]==0 and addr < BYTES), SHALL drive o_mem_en=1 and o_mem_addr=addr in the grant cycle; the next cycle, rdata SHALL equal i_mem_rdata and err SHALL be 0.
REQ-024 For an illegal address, SHALL still accept the request but hold o_mem_en=0; the next cycle SHALL return rvalid=1, err=1, rdata=32'h0000_0013 (NOP).
REQ-025 With no grant, o_mem_en SHALL be 0 and o_mem_addr SHALL hold its last value.
REQ-026 The responding path SHALL use a registered owner tag {NONE, IF, DBG} and a registered err bit; both update every cycle.
REQ-027 If i_if_flush=1 while the owner tag is IF, SHALL suppress o_if_rvalid that cycle.
REQ-028 If i_if_flush=1 in a cycle where fetch is granted, the grant SHALL proceed normally, so a new PC fetch can issue during flush.
REQ-029 i_if_flush SHALL NOT affect dbg traffic.
REQ-030 No response SHALL be dropped or duplicated except as defined by flush.

Reset
REQ-031 While i_reset=1: owner tag = NONE, starve_cnt = 0, o_mem_addr = 0, and o_if_rvalid, o_dbg_rvalid, o_if_err, o_dbg_err, o_mem_en, o_if_ready, o_dbg_ready all = 0; o_if_rdata = o_dbg_rdata = 0.
REQ-032 A request accepted in the cycle before reset asserts SHALL produce no response.
REQ-033 After i_reset deasserts, the first grant is possible in the same cycle.

Verification
REQ-034 Both valid for 6 cycles, STARVE_MAX=4 -> fetch granted cycles 0-3, dbg cycle 4, fetch cycle 5; each rvalid lands 1 cycle later on the correct port.
REQ-035 Fetch addr 0x4, ROM word1=0xDEADBEEF -> o_mem_en=1 with addr 0x4; next cycle o_if_rvalid=1, rdata=0xDEADBEEF, err=0.
REQ-036 Fetch addr 0x6, then dbg addr 0x2000 (BYTES=8192) -> o_mem_en stays 0; err responses with rdata 0x00000013 on each port.
REQ-037 Fetch 0x8 granted, i_if_flush=1 next cycle with a new fetch to 0x40 -> no response for 0x8; response for 0x40 delivered the following cycle.
REQ-038 Grant dbg, assert i_reset next cycle -> o_dbg_rvalid stays 0 and all outputs are at reset values.
REQ-039 Random valid/addr/flush for 10k cycles against a reference model -> every accepted non-flushed request gets exactly one correct, in-order response.
